// File: rtl/fft_reorder_64.sv
// Bit-reversed to natural-order reorder buffer for the 64-point FFT output.
// Ping-pong pair of complex banks; one bank fills while the other drains.
module fft_reorder_64 #(
  parameter int DW    = 24,
  parameter int LOG2N = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] din_r,
  input  logic [DW-1:0] din_i,
  output logic          out_valid,
  output logic [DW-1:0] dout_r,
  output logic [DW-1:0] dout_i,
  output logic          out_first,
  output logic          out_last
);

  localparam int N = 1 << LOG2N;
  localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);

  typedef enum logic {S_IDLE = 1'b0, S_READ = 1'b1} state_t;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    r = '0;
    for (int k = 0; k < LOG2N; k++) r[k] = a[LOG2N-1-k];
    return r;
  endfunction

  logic [2*DW-1:0]  r_mem [0:1][0:N-1];
  logic [LOG2N-1:0] r_wcnt;
  logic             r_wbank;
  logic [1:0]       r_full;
  state_t           r_state;
  logic             r_rbank;
  logic             r_exp_bank;
  logic [LOG2N-1:0] r_rcnt;
  logic             r_rd_valid;
  logic             r_rd_first;
  logic             r_rd_last;
  logic [2*DW-1:0]  r_rd_data;

  logic             w_wr_done;
  logic             w_rd_done;
  logic [1:0]       w_full_set;
  logic [1:0]       w_full_clr;
  logic [1:0]       w_full_nxt;

  assign w_wr_done = in_valid && (r_wcnt == LAST_IDX);
  assign w_rd_done = (r_state == S_READ) && (r_rcnt == LAST_IDX);

  // Per-bank full flag set/clear requests from writer and reader.
  always_comb begin
    w_full_set = 2'b00;
    w_full_clr = 2'b00;
    if (w_wr_done) begin
      w_full_set[r_wbank] = 1'b1;
    end else begin
      w_full_set = 2'b00;
    end
    if (w_rd_done) begin
      w_full_clr[r_rbank] = 1'b1;
    end else begin
      w_full_clr = 2'b00;
    end
    w_full_nxt = (r_full | w_full_set) & ~w_full_clr;
  end

  // Sample storage; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      r_mem[r_wbank][bitrev(r_wcnt)] <= {din_r, din_i};
    end
  end

  // Write counter, write bank and full flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wcnt  <= '0;
      r_wbank <= 1'b0;
      r_full  <= 2'b00;
    end else begin
      r_full <= w_full_nxt;
      if (in_valid) begin
        r_wcnt <= r_wcnt + LOG2N'(1);
        if (w_wr_done) begin
          r_wbank <= ~r_wbank;
        end
      end
    end
  end

  // Reader FSM: drains banks in alternating order, chaining with no idle cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_rbank    <= 1'b0;
      r_exp_bank <= 1'b0;
      r_rcnt     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_full[r_exp_bank]) begin
            r_state <= S_READ;
            r_rbank <= r_exp_bank;
            r_rcnt  <= '0;
          end
        end
        S_READ: begin
          r_rcnt <= r_rcnt + LOG2N'(1);
          if (r_rcnt == LAST_IDX) begin
            r_exp_bank <= ~r_rbank;
            // The other bank may have completed on this very edge.
            if (w_full_nxt[~r_rbank]) begin
              r_rbank <= ~r_rbank;
              r_rcnt  <= '0;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // RAM read register with aligned frame markers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_valid <= 1'b0;
      r_rd_first <= 1'b0;
      r_rd_last  <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= (r_state == S_READ);
      r_rd_first <= (r_state == S_READ) && (r_rcnt == '0);
      r_rd_last  <= w_rd_done;
      r_rd_data  <= r_mem[r_rbank][r_rcnt];
    end
  end

  // Output register; data forced to zero outside valid cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
      dout_r    <= '0;
      dout_i    <= '0;
    end else begin
      out_valid <= r_rd_valid;
      out_first <= r_rd_valid & r_rd_first;
      out_last  <= r_rd_valid & r_rd_last;
      dout_r    <= r_rd_valid ? r_rd_data[2*DW-1:DW] : '0;
      dout_i    <= r_rd_valid ? r_rd_data[DW-1:0]    : '0;
    end
  end

endmodule

// File: tb/tb_fft_reorder_64.sv
// Directed bench for fft_reorder_64 with a natural-order scoreboard queue.
module tb_fft_reorder_64;
  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] din_r = '0;
  logic [DW-1:0] din_i = '0;
  logic          out_valid;
  logic [DW-1:0] dout_r;
  logic [DW-1:0] dout_i;
  logic          out_first;
  logic          out_last;

  typedef struct packed {
    logic [DW-1:0] r;
    logic [DW-1:0] i;
    logic          f;
    logic          l;
  } exp_t;

  exp_t          q[$];
  logic [DW-1:0] fr_r[64];
  logic [DW-1:0] fr_i[64];
  int            wk = 0;
  int            n_checks = 0;
  int            n_errors = 0;
  int            out_cnt = 0;
  int            n_first = 0;
  int            n_last = 0;
  logic          prev_v = 1'b0;

  fft_reorder_64 #(.DW(DW), .LOG2N(6)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .din_r(din_r), .din_i(din_i),
    .out_valid(out_valid), .dout_r(dout_r), .dout_i(dout_i),
    .out_first(out_first), .out_last(out_last)
  );

  always #5 clk = ~clk;

  function automatic int bitrev6(input int k);
    int r;
    r = 0;
    for (int b = 0; b < 6; b++) if (((k >> b) & 1) != 0) r = r | (1 << (5 - b));
    return r;
  endfunction

  // Model: place sample at bitrev address; on frame completion push natural order.
  task automatic model_sample(input logic [DW-1:0] r, input logic [DW-1:0] i);
    exp_t e;
    fr_r[bitrev6(wk)] = r;
    fr_i[bitrev6(wk)] = i;
    wk = wk + 1;
    if (wk == 64) begin
      wk = 0;
      for (int n = 0; n < 64; n++) begin
        e.r = fr_r[n];
        e.i = fr_i[n];
        e.f = (n == 0);
        e.l = (n == 63);
        q.push_back(e);
      end
    end
  endtask

  task automatic send(input logic [DW-1:0] r, input logic [DW-1:0] i);
    in_valid = 1'b1;
    din_r = r;
    din_i = i;
    model_sample(r, i);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int base, input bit gapped);
    int v;
    for (int k = 0; k < 64; k++) begin
      v = base + bitrev6(k);
      send(DW'(v), DW'(0 - v));
      if (gapped) idle(1);
    end
  endtask

  task automatic wait_drain(input string tag);
    int t;
    t = 0;
    while (q.size() != 0 && t < 1000) begin
      @(posedge clk);
      t++;
    end
    idle(4);
    n_checks++;
    assert (q.size() == 0) else begin
      n_errors++;
      $error("FAIL %s drain: remaining=%0d required=0", tag, q.size());
    end
  endtask

  // Output monitor: pops and compares, checks zeroed idle data and bubbles.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_v <= 1'b0;
    end else begin
      if (out_valid) begin
        n_checks++;
        assert (q.size() != 0) else begin
          n_errors++;
          $error("FAIL unexpected_out: dout_r=%h with empty scoreboard", dout_r);
        end
        if (q.size() != 0) begin
          e = q.pop_front();
          n_checks++;
          assert ({dout_r, dout_i, out_first, out_last} === {e.r, e.i, e.f, e.l}) else begin
            n_errors++;
            $error("FAIL out_data: got r=%h i=%h f=%b l=%b required r=%h i=%h f=%b l=%b",
                   dout_r, dout_i, out_first, out_last, e.r, e.i, e.f, e.l);
          end
        end
        out_cnt++;
        if (out_first) n_first++;
        if (out_last) n_last++;
      end else begin
        n_checks++;
        assert (dout_r === '0 && dout_i === '0 && out_first === 1'b0 && out_last === 1'b0) else begin
          n_errors++;
          $error("FAIL idle_zero: r=%h i=%h f=%b l=%b required all 0", dout_r, dout_i, out_first, out_last);
        end
        n_checks++;
        assert (!(prev_v && q.size() != 0)) else begin
          n_errors++;
          $error("FAIL bubble: out_valid=0 with %0d pending required 1", q.size());
        end
      end
      prev_v <= out_valid;
    end
  end

  initial begin
    int t;
    int n;
    logic [DW-1:0] v;

    idle(3);
    n_checks++;
    assert (out_valid === 1'b0 && out_first === 1'b0 && out_last === 1'b0) else begin
      n_errors++;
      $error("FAIL reset_flags: v=%b f=%b l=%b required 000", out_valid, out_first, out_last);
    end
    n_checks++;
    assert (dout_r === '0 && dout_i === '0) else begin
      n_errors++;
      $error("FAIL reset_data: r=%h i=%h required 0", dout_r, dout_i);
    end
    rst = 1'b0;
    idle(2);

    // Single frame with exact latency check.
    send_frame(0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      assert (out_valid === 1'b0) else begin
        n_errors++;
        $error("FAIL latency_early: cyc=%0d out_valid=%b required 0", c, out_valid);
      end
    end
    @(negedge clk);
    n_checks++;
    assert (out_valid === 1'b1 && out_first === 1'b1) else begin
      n_errors++;
      $error("FAIL latency_first: v=%b f=%b required 11", out_valid, out_first);
    end
    wait_drain("single");

    // Four back-to-back frames.
    out_cnt = 0; n_first = 0; n_last = 0;
    for (int f = 0; f < 4; f++) send_frame(f * 64, 1'b0);
    wait_drain("b2b");
    n_checks++;
    assert (out_cnt == 256 && n_first == 4 && n_last == 4) else begin
      n_errors++;
      $error("FAIL b2b_counts: outs=%0d firsts=%0d lasts=%0d required 256 4 4", out_cnt, n_first, n_last);
    end

    // Gapped input.
    out_cnt = 0;
    send_frame(0, 1'b1);
    wait_drain("gapped");
    n_checks++;
    assert (out_cnt == 64) else begin
      n_errors++;
      $error("FAIL gapped_count: outs=%0d required 64", out_cnt);
    end

    // Signed extremes in natural index order.
    for (int k = 0; k < 64; k++) begin
      n = bitrev6(k);
      v = ((n % 2) == 0) ? 24'h7FFFFF : 24'h800000;
      send(v, ~v);
    end
    wait_drain("extremes");

    // Reset mid input frame.
    out_cnt = 0;
    for (int k = 0; k < 40; k++) send(DW'(500 + k), DW'(k));
    rst = 1'b1;
    wk = 0;
    idle(2);
    rst = 1'b0;
    idle(1);
    send_frame(1000, 1'b0);
    wait_drain("rst_mid_frame");
    n_checks++;
    assert (out_cnt == 64) else begin
      n_errors++;
      $error("FAIL rst_mid_count: outs=%0d required 64", out_cnt);
    end

    // Reset during readout.
    out_cnt = 0;
    send_frame(2000, 1'b0);
    t = 0;
    while (out_cnt < 20 && t < 500) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    assert (out_cnt >= 20) else begin
      n_errors++;
      $error("FAIL readout_wait: outs=%0d required 20", out_cnt);
    end
    #1;
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    assert (out_valid === 1'b0 && dout_r === '0 && dout_i === '0) else begin
      n_errors++;
      $error("FAIL rst_readout: v=%b r=%h i=%h required 0 0 0", out_valid, dout_r, dout_i);
    end
    q.delete();
    wk = 0;
    idle(2);
    rst = 1'b0;
    idle(1);
    out_cnt = 0;
    send_frame(3000, 1'b0);
    wait_drain("after_rst");
    n_checks++;
    assert (out_cnt == 64) else begin
      n_errors++;
      $error("FAIL after_rst_count: outs=%0d required 64", out_cnt);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
